fx2_host_model: RTL and testbench

Behavioural-but-synthesizable model of the Cypress FX2 slave-FIFO interface as seen from the FPGA, with a USB host stub. It sits in the bench between the command stimulus and the timetagger FPGA top. Command bytes queued by the bench become readable on endpoint EP2 only after a commit, and a completion pulse fires once the FPGA has drained them. Bytes the FPGA writes to EP6 are sunk, exposed on a monitor port, and throttled per packet.

---
 rtl/fx2_pkg.sv | 28 ++
 rtl/fx2_commit_fifo.sv | 66 ++++++
 rtl/fx2_host_model.sv | 139 +++++++++++++
 tb/tb_fx2_host_model.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 slave-FIFO host model: endpoint
// addresses, flag bit positions and pointer sizing.
package fx2_pkg;

    // FIFOADR encodings as seen on the slave-FIFO bus
    typedef enum logic [1:0] {
        EP_ADDR_EP2 = 2'b00,
        EP_ADDR_EP4 = 2'b01,
        EP_ADDR_EP6 = 2'b10,
        EP_ADDR_EP8 = 2'b11
    } ep_addr_e;

    localparam logic [1:0] EP2 = EP_ADDR_EP2;
    localparam logic [1:0] EP4 = EP_ADDR_EP4;
    localparam logic [1:0] EP6 = EP_ADDR_EP6;
    localparam logic [1:0] EP8 = EP_ADDR_EP8;

    // Bit positions inside the flags bus
    localparam int FLAG_EP2_NE = 0;
    localparam int FLAG_EP6_NF = 1;
    localparam int FLAG_RSVD   = 2;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    function automatic int ptrBits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fx2_commit_fifo.sv
// Command buffer behind EP2: a circular RAM with write, commit and read
// pointers. Bytes between commit and write are staged and invisible to
// the reader; bytes between read and commit are readable.
module fx2_commit_fifo
    import fx2_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic [7:0] i_wdata,
    input  logic       i_commit,
    input  logic       i_rd,
    output logic [7:0] o_rdata,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_drainedNext
);

    localparam int PW = ptrBits(DEPTH);
    localparam int AW = PW - 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_commitPtr;
    logic [PW-1:0] r_rdPtr;

    logic [PW-1:0] w_wrPtrNext;
    logic [PW-1:0] w_rdPtrNext;
    logic [PW-1:0] w_commitPtrNext;
    logic [PW-1:0] w_used;

    // The caller qualifies i_wr with o_full and i_rd with o_empty
    assign w_wrPtrNext     = i_wr ? r_wrPtr + PW'(1) : r_wrPtr;
    assign w_rdPtrNext     = i_rd ? r_rdPtr + PW'(1) : r_rdPtr;
    // A commit also covers a byte written on the same edge
    assign w_commitPtrNext = i_commit ? w_wrPtrNext : r_commitPtr;

    assign w_used        = r_wrPtr - r_rdPtr;
    assign o_full        = (w_used == PW'(DEPTH));
    assign o_empty       = (r_rdPtr == r_commitPtr);
    assign o_drainedNext = (w_rdPtrNext == w_commitPtrNext);
    assign o_rdata       = r_mem[r_rdPtr[AW-1:0]];

    // Storage array; contents need no reset because pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
        end
    end

    // Pointer registers; reset throws away staged and committed bytes alike
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr     <= '0;
            r_commitPtr <= '0;
            r_rdPtr     <= '0;
        end else begin
            r_wrPtr     <= w_wrPtrNext;
            r_commitPtr <= w_commitPtrNext;
            r_rdPtr     <= w_rdPtrNext;
        end
    end

endmodule

// File: rtl/fx2_host_model.sv
// FX2 slave-FIFO model as seen from the FPGA. EP2 serves bench commands
// once committed, EP6 sinks FPGA data with per-packet host-drain throttling.
module fx2_host_model
    import fx2_pkg::*;
#(
    parameter int IN_PKT       = 512,
    parameter int DRAIN_CYCLES = 16,
    parameter int CMD_DEPTH    = 64
) (
    input  logic       clk,
    input  logic       reset,
    output logic       ifclk,
    inout  wire  [7:0] fd,
    input  logic       slrd,
    input  logic       slwr,
    input  logic       sloe,
    input  logic [1:0] fifoadr,
    input  logic       pktend,
    output logic [2:0] flags,
    input  logic [7:0] cmd_data,
    input  logic       cmd_wr,
    input  logic       cmd_commit,
    output logic       cmd_sent,
    output logic [7:0] in_data,
    output logic       in_valid
);

    localparam int CW = $clog2(IN_PKT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    logic          w_selEp2;
    logic          w_selEp6;
    logic          w_cmdEmpty;
    logic          w_cmdFull;
    logic          w_drainedNext;
    logic          w_cmdWrEn;
    logic          w_cmdRdEn;
    logic [7:0]    w_rdData;
    logic          w_ep6Full;
    logic          w_ep6Wr;
    logic          w_lastByte;
    logic          w_close;

    logic          r_pending;
    logic [CW-1:0] r_pktCount;
    logic [DW-1:0] r_drain;

    assign ifclk = clk;

    // Endpoint decode; EP4 and EP8 exist on the bus but do nothing here
    always_comb begin
        w_selEp2 = 1'b0;
        w_selEp6 = 1'b0;
        case (fifoadr)
            EP2:      w_selEp2 = 1'b1;
            EP6:      w_selEp6 = 1'b1;
            EP4, EP8: ;
            default:  ;
        endcase
    end

    assign w_cmdWrEn = cmd_wr && !w_cmdFull;
    assign w_cmdRdEn = !slrd && w_selEp2 && !w_cmdEmpty;

    fx2_commit_fifo #(
        .DEPTH(CMD_DEPTH)
    ) u_cmdFifo (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_wr         (w_cmdWrEn),
        .i_wdata      (cmd_data),
        .i_commit     (cmd_commit),
        .i_rd         (w_cmdRdEn),
        .o_rdata      (w_rdData),
        .o_empty      (w_cmdEmpty),
        .o_full       (w_cmdFull),
        .o_drainedNext(w_drainedNext)
    );

    // First-word-fall-through: the head byte sits on the bus while EP2 is output-enabled
    assign fd = (!sloe && w_selEp2) ? w_rdData : 8'bz;

    assign w_ep6Full  = (r_drain != '0);
    assign w_ep6Wr    = !slwr && w_selEp6 && !w_ep6Full;
    assign w_lastByte = w_ep6Wr && (r_pktCount == CW'(IN_PKT - 1));
    // A byte arriving with pktend still counts toward the packet it closes
    assign w_close    = !w_ep6Full && ((w_selEp6 && !pktend) || w_lastByte);

    // Flag bus assembled from registered state only
    always_comb begin
        flags              = '0;
        flags[FLAG_EP2_NE] = !w_cmdEmpty;
        flags[FLAG_EP6_NF] = !w_ep6Full;
        flags[FLAG_RSVD]   = 1'b1;
    end

    // Completion tracking: one pulse once every committed byte has been consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            cmd_sent  <= 1'b0;
        end else if (r_pending && w_drainedNext) begin
            r_pending <= 1'b0;
            cmd_sent  <= 1'b1;
        end else begin
            cmd_sent <= 1'b0;
            if (cmd_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    // EP6 sink: capture bytes, count the packet, hold full while the host drains
    always_ff @(posedge clk) begin
        if (reset) begin
            in_data    <= '0;
            in_valid   <= 1'b0;
            r_pktCount <= '0;
            r_drain    <= '0;
        end else begin
            in_valid <= w_ep6Wr;
            if (w_ep6Wr) begin
                in_data <= fd;
            end
            if (w_close) begin
                r_pktCount <= '0;
                r_drain    <= DW'(DRAIN_CYCLES);
            end else begin
                if (w_ep6Wr) begin
                    r_pktCount <= r_pktCount + CW'(1);
                end
                if (w_ep6Full) begin
                    r_drain <= r_drain - DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fx2_host_model.sv
// Bench for fx2_host_model: a queue-based host model checked every cycle,
// plus directed literal expectations for the scenarios of interest.
module tb_fx2_host_model;

    localparam int IN_PKT    = 512;
    localparam int DRAIN     = 16;
    localparam int CMD_DEPTH = 64;

    localparam int OP_IDLE      = 0;
    localparam int OP_CWR       = 1;
    localparam int OP_COMMIT    = 2;
    localparam int OP_CWRCOMMIT = 3;
    localparam int OP_READ      = 4;
    localparam int OP_EP6WR     = 5;
    localparam int OP_PKTEND    = 6;
    localparam int OP_EP6WREND  = 7;
    localparam int OP_READEP4   = 8;
    localparam int OP_RESET     = 9;

    logic       clk;
    logic       reset;
    logic       ifclk;
    wire  [7:0] fd;
    logic       slrd;
    logic       slwr;
    logic       sloe;
    logic [1:0] fifoadr;
    logic       pktend;
    logic [2:0] flags;
    logic [7:0] cmd_data;
    logic       cmd_wr;
    logic       cmd_commit;
    logic       cmd_sent;
    logic [7:0] in_data;
    logic       in_valid;

    logic       tbDrive;
    logic [7:0] tbData;

    int checks;
    int failures;
    int sentCount;
    int ivCount;
    int fullCount;
    logic checking;

    // Host-level model state
    logic [7:0] stageQ[$];
    logic [7:0] visQ[$];
    logic       mPending;
    logic       expSent;
    logic       expInValid;
    logic [7:0] expInData;
    int         pktCnt;
    int         drainLeft;

    assign fd = tbDrive ? tbData : 8'bz;

    fx2_host_model #(
        .IN_PKT      (IN_PKT),
        .DRAIN_CYCLES(DRAIN),
        .CMD_DEPTH   (CMD_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ifclk     (ifclk),
        .fd        (fd),
        .slrd      (slrd),
        .slwr      (slwr),
        .sloe      (sloe),
        .fifoadr   (fifoadr),
        .pktend    (pktend),
        .flags     (flags),
        .cmd_data  (cmd_data),
        .cmd_wr    (cmd_wr),
        .cmd_commit(cmd_commit),
        .cmd_sent  (cmd_sent),
        .in_data   (in_data),
        .in_valid  (in_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of bus activity, changing inputs just after the rising edge
    task automatic applyStimulus(input int op, input logic [7:0] val);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        cmd_wr     = 1'b0;
        cmd_commit = 1'b0;
        cmd_data   = 8'h00;
        slrd       = 1'b1;
        slwr       = 1'b1;
        sloe       = 1'b1;
        fifoadr    = 2'b00;
        pktend     = 1'b1;
        tbDrive    = 1'b0;
        tbData     = 8'h00;
        case (op)
            OP_CWR:       begin cmd_wr = 1'b1; cmd_data = val; end
            OP_COMMIT:    cmd_commit = 1'b1;
            OP_CWRCOMMIT: begin cmd_wr = 1'b1; cmd_data = val; cmd_commit = 1'b1; end
            OP_READ:      begin slrd = 1'b0; sloe = 1'b0; fifoadr = 2'b00; end
            OP_READEP4:   begin slrd = 1'b0; sloe = 1'b0; fifoadr = 2'b01; end
            OP_EP6WR:     begin slwr = 1'b0; fifoadr = 2'b10; tbDrive = 1'b1; tbData = val; end
            OP_PKTEND:    begin pktend = 1'b0; fifoadr = 2'b10; end
            OP_EP6WREND:  begin slwr = 1'b0; pktend = 1'b0; fifoadr = 2'b10; tbDrive = 1'b1; tbData = val; end
            OP_RESET:     reset = 1'b1;
            default:      ;
        endcase
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(OP_IDLE, 8'h00);
    endtask

    task automatic readCheck(input string name, input logic [7:0] exp);
        applyStimulus(OP_READ, 8'h00);
        @(negedge clk);
        checkOutput(name, fd, exp);
    endtask

    // Host model: advances on each rising edge from the inputs held over the previous cycle
    always @(posedge clk) begin : modelProc
        int total;
        if (reset) begin
            stageQ.delete();
            visQ.delete();
            mPending   = 1'b0;
            expSent    = 1'b0;
            expInValid = 1'b0;
            expInData  = 8'h00;
            pktCnt     = 0;
            drainLeft  = 0;
        end else begin
            total = stageQ.size() + visQ.size();
            if (!slrd && fifoadr == 2'b00 && visQ.size() > 0) void'(visQ.pop_front());
            if (cmd_wr && total < CMD_DEPTH) stageQ.push_back(cmd_data);
            if (cmd_commit) begin
                while (stageQ.size() > 0) visQ.push_back(stageQ.pop_front());
            end
            if (mPending && visQ.size() == 0) begin
                expSent  = 1'b1;
                mPending = 1'b0;
            end else begin
                expSent = 1'b0;
                if (cmd_commit) mPending = 1'b1;
            end
            expInValid = 1'b0;
            if (!slwr && fifoadr == 2'b10 && drainLeft == 0) begin
                expInValid = 1'b1;
                expInData  = tbData;
                pktCnt++;
            end
            if (drainLeft == 0 && ((fifoadr == 2'b10 && !pktend) || pktCnt == IN_PKT)) begin
                pktCnt    = 0;
                drainLeft = DRAIN;
            end else if (drainLeft > 0) begin
                drainLeft--;
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model, plus event tallies
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("flags", flags, {1'b1, drainLeft == 0, visQ.size() != 0});
            checkOutput("cmd_sent", cmd_sent, expSent);
            checkOutput("in_valid", in_valid, expInValid);
            checkOutput("in_data", in_data, expInData);
            if (!sloe && fifoadr == 2'b00 && !tbDrive && visQ.size() > 0)
                checkOutput("fdHead", fd, visQ[0]);
            if (cmd_sent) sentCount++;
            if (in_valid) ivCount++;
            if (!flags[1]) fullCount++;
        end
    end

    initial begin
        int n;
        checks = 0; failures = 0; sentCount = 0; ivCount = 0; fullCount = 0;
        checking = 1'b0;
        reset = 1'b1; cmd_wr = 1'b0; cmd_commit = 1'b0; cmd_data = 8'h00;
        slrd = 1'b1; slwr = 1'b1; sloe = 1'b1; fifoadr = 2'b00; pktend = 1'b1;
        tbDrive = 1'b0; tbData = 8'h00;

        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("resetFlags", flags, 3'b110);
        checkOutput("resetCmdSent", cmd_sent, 1'b0);
        checkOutput("resetInValid", in_valid, 1'b0);
        checkOutput("resetInData", in_data, 8'h00);
        checking = 1'b1;

        // Three FF bytes, commit, drain
        for (int i = 0; i < 3; i++) applyStimulus(OP_CWR, 8'hFF);
        applyStimulus(OP_COMMIT, 8'h00);
        applyStimulus(OP_IDLE, 8'h00);
        @(negedge clk);
        checkOutput("ep2NotEmptyAfterCommit", flags[0], 1'b1);
        sentCount = 0;
        for (int i = 0; i < 3; i++) readCheck("readFF", 8'hFF);
        applyStimulus(OP_IDLE, 8'h00);
        @(negedge clk);
        checkOutput("ep2EmptyAfterDrain", flags[0], 1'b0);
        checkOutput("cmdSentAfterLastRead", cmd_sent, 1'b1);
        idleCycles(4);
        @(negedge clk);
        checkOutput("cmdSentOnce", sentCount, 1);

        // Staged bytes stay invisible until committed
        applyStimulus(OP_CWR, 8'hAA);
        for (int i = 0; i < 3; i++) applyStimulus(OP_CWR, 8'h01);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(OP_IDLE, 8'h00);
            @(negedge clk);
            checkOutput("uncommittedHidden", flags[0], 1'b0);
        end
        applyStimulus(OP_COMMIT, 8'h00);
        readCheck("readAA", 8'hAA);
        for (int i = 0; i < 3; i++) readCheck("read01", 8'h01);
        idleCycles(2);

        // Zero-byte commit pulses one cycle later
        applyStimulus(OP_COMMIT, 8'h00);
        applyStimulus(OP_IDLE, 8'h00);
        @(negedge clk);
        checkOutput("zeroCommitNoPulseYet", cmd_sent, 1'b0);
        applyStimulus(OP_IDLE, 8'h00);
        @(negedge clk);
        checkOutput("zeroCommitPulse", cmd_sent, 1'b1);

        // EP4 strobes are inert
        applyStimulus(OP_CWR, 8'h3C);
        applyStimulus(OP_COMMIT, 8'h00);
        applyStimulus(OP_READEP4, 8'h00);
        applyStimulus(OP_IDLE, 8'h00);
        @(negedge clk);
        checkOutput("ep4ReadIgnored", flags[0], 1'b1);
        readCheck("read3C", 8'h3C);
        idleCycles(2);

        // Full 512-byte packet, a dropped write, then the drain window
        ivCount = 0;
        for (int i = 0; i < IN_PKT; i++) applyStimulus(OP_EP6WR, 8'(i));
        fullCount = 0;
        applyStimulus(OP_EP6WR, 8'h77);
        idleCycles(20);
        @(negedge clk);
        checkOutput("pktInValidCount", ivCount, 512);
        checkOutput("pktDrainCycles", fullCount, 16);
        checkOutput("droppedWriteKeepsData", in_data, 8'hFF);

        // Short packet closed by pktend
        fullCount = 0;
        for (int i = 0; i < 5; i++) applyStimulus(OP_EP6WR, 8'h10 + 8'(i));
        applyStimulus(OP_PKTEND, 8'h00);
        idleCycles(20);
        @(negedge clk);
        checkOutput("pktendDrainCycles", fullCount, 16);

        // Byte written alongside pktend joins the closing packet
        ivCount = 0;
        fullCount = 0;
        for (int i = 0; i < 3; i++) applyStimulus(OP_EP6WR, 8'h40 + 8'(i));
        applyStimulus(OP_EP6WREND, 8'h5A);
        idleCycles(20);
        @(negedge clk);
        checkOutput("pktendWithByteCount", ivCount, 4);
        checkOutput("pktendWithByteData", in_data, 8'h5A);
        checkOutput("pktendWithByteDrain", fullCount, 16);

        // Overfill staging: the 65th byte is lost
        for (int i = 0; i < 65; i++) applyStimulus(OP_CWR, 8'(i + 1));
        applyStimulus(OP_COMMIT, 8'h00);
        applyStimulus(OP_IDLE, 8'h00);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(OP_READ, 8'h00);
            applyStimulus(OP_IDLE, 8'h00);
            @(negedge clk);
            n++;
            if (!flags[0]) break;
        end
        checkOutput("overfillReadCount", n, 64);

        // Write and commit on the same edge
        applyStimulus(OP_CWR, 8'h11);
        applyStimulus(OP_CWRCOMMIT, 8'h5C);
        readCheck("sameCycleFirst", 8'h11);
        readCheck("sameCycleSecond", 8'h5C);
        applyStimulus(OP_IDLE, 8'h00);
        @(negedge clk);
        checkOutput("sameCycleDrained", flags[0], 1'b0);

        // Reset in the middle of traffic
        applyStimulus(OP_CWR, 8'h01);
        applyStimulus(OP_CWR, 8'h02);
        applyStimulus(OP_COMMIT, 8'h00);
        applyStimulus(OP_CWR, 8'h03);
        applyStimulus(OP_EP6WR, 8'hC1);
        applyStimulus(OP_PKTEND, 8'h00);
        applyStimulus(OP_IDLE, 8'h00);
        applyStimulus(OP_RESET, 8'h00);
        applyStimulus(OP_IDLE, 8'h00);
        @(negedge clk);
        checkOutput("midResetFlags", flags, 3'b110);
        checkOutput("midResetInData", in_data, 8'h00);
        idleCycles(3);
        @(negedge clk);
        checkOutput("midResetStaysEmpty", flags, 3'b110);

        idleCycles(2);
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog bound on the whole run
    initial begin
        #500000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
